// File: rtl/grayscale_stream_if.sv
// Stream bundle for grayscale_stream.
// Purpose: groups the RGB input stream (valid/ready plus pixel, rounding mode
// and algorithm select) with the gray output stream (valid/ready plus gray
// sample and end-of-line flag).
// Ports (signals):
//   in_valid, in_ready     input-side handshake
//   color[3*CW-1:0]        {R,G,B}, R in the MSBs
//   mode[1:0]              0 ceil, 1 floor, 2 half-to-even, 3 half-up
//   algo                   0 mean, 1 BT.601 luma
//   out_valid, out_ready   output-side handshake
//   gray[CW-1:0]           rounded gray sample
//   out_eol                last pixel of a line, qualifies gray
// Modports: master = pixel source / gray sink, slave = the converter.
interface grayscale_stream_if #(
  parameter int CW = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [3*CW-1:0] color;
  logic [1:0]      mode;
  logic            algo;
  logic            out_valid;
  logic            out_ready;
  logic [CW-1:0]   gray;
  logic            out_eol;

  modport master (
    output in_valid, color, mode, algo, out_ready,
    input  in_ready, out_valid, gray, out_eol
  );

  modport slave (
    input  in_valid, color, mode, algo, out_ready,
    output in_ready, out_valid, gray, out_eol
  );
endinterface

// File: rtl/grayscale_stream.sv
// Two-stage streaming RGB-to-gray converter.
// Purpose: accepts one packed RGB pixel per beat, forms the exact channel sum
// (mean) or weighted sum (luma) in stage 1, rounds and saturates it in stage 2,
// and flags the last pixel of each IMG_W-pixel line on the output.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset; holds in_ready low while asserted
//   bus   grayscale_stream_if.slave (input stream in, gray stream out)
// Parameters:
//   CW     bits per colour channel and per gray sample
//   IMG_W  pixels per line
module grayscale_stream #(
  parameter int CW    = 8,
  parameter int IMG_W = 640
) (
  input logic               clk,
  input logic               rst,
  grayscale_stream_if.slave bus
);

  // The luma weights sum to 256, so CW+8 bits hold either sum exactly.
  localparam int SW    = CW + 8;
  localparam int RW    = SW + 1;
  localparam int CNT_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(IMG_W - 1);
  localparam logic [RW-1:0]    GRAY_MAX = RW'({CW{1'b1}});

  typedef enum logic [1:0] {
    RND_CEIL  = 2'd0,
    RND_FLOOR = 2'd1,
    RND_EVEN  = 2'd2,
    RND_UP    = 2'd3
  } rnd_e;

  logic             s1_valid;
  logic [SW-1:0]    s1_sum;
  rnd_e             s1_mode;
  logic             s1_algo;
  logic             s2_valid;
  logic [CW-1:0]    s2_gray;
  logic [CNT_W-1:0] pix_cnt;

  logic s1_load, s2_load, in_xfer, out_xfer;

  // A stage loads when it is empty or its content moves on this cycle, so
  // bubbles collapse and a full pipeline still streams one beat per cycle.
  assign out_xfer     = s2_valid && bus.out_ready;
  assign s2_load      = !s2_valid || bus.out_ready;
  assign s1_load      = !s1_valid || s2_load;
  assign bus.in_ready = !rst && s1_load;
  assign in_xfer      = bus.in_valid && bus.in_ready;

  // Stage 1 input: exact sum, no rounding yet.
  logic [SW-1:0] ch_r, ch_g, ch_b, sum_in;
  assign ch_r = SW'(bus.color[3*CW-1 -: CW]);
  assign ch_g = SW'(bus.color[2*CW-1 -: CW]);
  assign ch_b = SW'(bus.color[CW-1:0]);

  // NOTE: every variable written in an always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    sum_in = ch_r + ch_g + ch_b;
    if (bus.algo) begin
      sum_in = SW'(77) * ch_r + SW'(150) * ch_g + SW'(29) * ch_b;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // Data registers are reset too: gray must read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_mode  <= RND_CEIL;
      s1_algo  <= 1'b0;
    end else if (s1_load) begin
      // mode/algo are captured with the pixel and travel with it.
      s1_valid <= in_xfer;
      s1_sum   <= sum_in;
      s1_mode  <= rnd_e'(bus.mode);
      s1_algo  <= bus.algo;
    end
  end

  // Stage 2 input: quotient, fractional part classification, rounding.
  logic [SW-1:0] q, rem3;
  logic          frac_nz, frac_gt, frac_eq, round_up;
  logic [RW-1:0] rounded;
  logic [CW-1:0] gray_next;

  always_comb begin
    rem3    = s1_sum % SW'(3);
    q       = s1_sum / SW'(3);
    // Mean: a remainder of 2 means 2/3 > half; 1/3 < half; exact half is impossible.
    frac_nz = (rem3 != '0);
    frac_gt = (rem3 == SW'(2));
    frac_eq = 1'b0;
    if (s1_algo) begin
      q       = s1_sum >> 8;
      frac_nz = (s1_sum[7:0] != 8'd0);
      frac_gt = (s1_sum[7:0] >  8'd128);
      frac_eq = (s1_sum[7:0] == 8'd128);
    end

    round_up = 1'b0;
    case (s1_mode)
      RND_CEIL:  round_up = frac_nz;
      RND_FLOOR: round_up = 1'b0;
      RND_EVEN:  round_up = frac_gt || (frac_eq && q[0]);
      RND_UP:    round_up = frac_gt || frac_eq;
      default:   round_up = 1'b0;
    endcase

    rounded   = {1'b0, q} + RW'(round_up);
    gray_next = (rounded > GRAY_MAX) ? {CW{1'b1}} : rounded[CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_gray  <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      s2_gray  <= gray_next;
    end
  end

  // Line position of the beat currently presented; advances only on transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt <= '0;
    end else if (out_xfer) begin
      pix_cnt <= (pix_cnt == LAST_PIX) ? '0 : pix_cnt + CNT_W'(1);
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.gray      = s2_gray;
  assign bus.out_eol   = s2_valid && (pix_cnt == LAST_PIX);

endmodule

// File: tb/tb_grayscale_stream.sv
// Self-checking bench for grayscale_stream (CW=8, IMG_W=4).
// Drives inputs and samples outputs 1 ns after the falling edge.
module tb_grayscale_stream;

  typedef struct {
    logic [23:0] color;
    logic [1:0]  mode;
    logic        algo;
    logic [7:0]  exp_gray;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;
  vec_t vecs[$];

  grayscale_stream_if #(.CW(8)) bus ();

  grayscale_stream #(.CW(8), .IMG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic add(input logic [23:0] c, input logic [1:0] m, input logic a,
                     input logic [7:0] g);
    vec_t v;
    v.color = c; v.mode = m; v.algo = a; v.exp_gray = g;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    bus.color = v.color;
    bus.mode  = v.mode;
    bus.algo  = v.algo;
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int sent, got, first_in, first_out;
    vec_t q_exp[$];
    vec_t e;

    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.color     = '0;
    bus.mode      = 2'd0;
    bus.algo      = 1'b0;

    // {color, mode, algo, expected gray}, hand-computed.
    add(24'h000001, 2'd0, 1'b0, 8'd1);   add(24'h000001, 2'd1, 1'b0, 8'd0);
    add(24'h000001, 2'd2, 1'b0, 8'd0);   add(24'h000001, 2'd3, 1'b0, 8'd0);
    add(24'h000002, 2'd0, 1'b0, 8'd1);   add(24'h000002, 2'd1, 1'b0, 8'd0);
    add(24'h000002, 2'd2, 1'b0, 8'd1);   add(24'h000002, 2'd3, 1'b0, 8'd1);
    add(24'h000080, 2'd0, 1'b1, 8'd15);  add(24'h000080, 2'd1, 1'b1, 8'd14);
    add(24'h000080, 2'd2, 1'b1, 8'd14);  add(24'h000080, 2'd3, 1'b1, 8'd15);
    for (int m = 0; m < 4; m++) begin
      add(24'hFFFFFF, 2'(m), 1'b1, 8'd255);
      add(24'hFFFFFF, 2'(m), 1'b0, 8'd255);
    end
    // luma 29056 = 113*256 + 128: half with odd q
    add(24'h808000, 2'd0, 1'b1, 8'd114); add(24'h808000, 2'd1, 1'b1, 8'd113);
    add(24'h808000, 2'd2, 1'b1, 8'd114); add(24'h808000, 2'd3, 1'b1, 8'd114);
    // luma 145: fraction above half with q = 0
    add(24'h000005, 2'd0, 1'b1, 8'd1);   add(24'h000005, 2'd1, 1'b1, 8'd0);
    add(24'h000005, 2'd2, 1'b1, 8'd1);   add(24'h000005, 2'd3, 1'b1, 8'd1);
    // mean 34 (r=1) and 35 (r=2)
    add(24'h0A0B0D, 2'd0, 1'b0, 8'd12);  add(24'h0A0B0D, 2'd1, 1'b0, 8'd11);
    add(24'h0A0B0D, 2'd2, 1'b0, 8'd11);  add(24'h0A0B0D, 2'd3, 1'b0, 8'd11);
    add(24'h0A0B0E, 2'd0, 1'b0, 8'd12);  add(24'h0A0B0E, 2'd1, 1'b0, 8'd11);
    add(24'h0A0B0E, 2'd2, 1'b0, 8'd12);  add(24'h0A0B0E, 2'd3, 1'b0, 8'd12);
    // exact results: luma 7424 = 29*256, mean 96/3 = 32
    add(24'h102030, 2'd0, 1'b1, 8'd29);  add(24'h102030, 2'd0, 1'b0, 8'd32);

    // Reset state
    tick();
    check("rst_in_ready_low", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_rst_gray", 32'(bus.gray), 32'd0);
    check("post_rst_eol", 32'(bus.out_eol), 32'd0);

    // Table: one beat at a time, exact 2-cycle latency, rounded value.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      check($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.color    = 24'h5A5A5A;
      bus.mode     = ~vecs[i].mode;
      bus.algo     = ~vecs[i].algo;
      #1;
      check($sformatf("v%0d_lat1_valid", i), 32'(bus.out_valid), 32'd0);
      tick();
      check($sformatf("v%0d_lat2_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("v%0d_gray", i), 32'(bus.gray), 32'(vecs[i].exp_gray));
    end

    // Stream 8 beats with random back-pressure; mixed modes travel with pixels.
    do_reset();
    sent = 0; got = 0; first_in = -1; first_out = -1;
    for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
      @(negedge clk);
      bus.out_ready = (cyc < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.in_valid  = (sent < 8);
      if (sent < 8) drive(vecs[20 + sent]);
      #1;
      if (bus.out_valid && first_out < 0) first_out = cyc;
      if (bus.out_valid && bus.out_ready) begin
        if (q_exp.size() == 0) begin
          check("stream_extra_beat", 32'd1, 32'd0);
        end else begin
          e = q_exp.pop_front();
          check($sformatf("stream_gray%0d", got), 32'(bus.gray), 32'(e.exp_gray));
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        if (first_in < 0) first_in = cyc;
        q_exp.push_back(vecs[20 + sent]);
        sent++;
      end
    end
    check("stream_count", 32'(got), 32'd8);
    check("stream_first_latency", 32'(first_out - first_in), 32'd2);
    bus.in_valid = 1'b0;

    // Line counter, IMG_W=4, reset with two beats in flight.
    do_reset();
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = (sent < 10);
      if (sent < 10) drive(vecs[sent]);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("line_gray%0d", got), 32'(bus.gray), 32'(vecs[got].exp_gray));
        check($sformatf("line_eol%0d", got), 32'(bus.out_eol), 32'((got % 4) == 3));
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
    end
    check("line_got_before_rst", 32'(got), 32'd8);
    check("line_sent_before_rst", 32'(sent), 32'd10);

    @(negedge clk);
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("inflight_valid", 32'(bus.out_valid), 32'd1);
    check("rst_hold_in_ready0", 32'(bus.in_ready), 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      drive(vecs[0]);
      #1;
      check($sformatf("rst_hold_in_ready%0d", k + 1), 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("after_rst_in_ready", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("flushed%0d", k), 32'(bus.out_valid), 32'd0);
    end

    sent = 0; got = 0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      @(negedge clk);
      bus.in_valid = (sent < 4);
      if (sent < 4) drive(vecs[12 + sent]);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("new_gray%0d", got), 32'(bus.gray), 32'(vecs[12 + got].exp_gray));
        check($sformatf("new_eol%0d", got), 32'(bus.out_eol), 32'(got == 3));
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
    end
    check("new_line_count", 32'(got), 32'd4);
    bus.in_valid = 1'b0;
    tick();
    check("no_extra_after_line", 32'(bus.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
